// File: rtl/gcm_ghash_sched.sv
// GHASH input scheduler for one AES-GCM message.
// Emits masked AAD blocks, ciphertext blocks, then len(A)||len(C).
module gcm_ghash_sched #(
    parameter int CNT_W = 16,
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] aad_total,
    input  logic [CNT_W-1:0] ct_total,
    input  logic [127:0]     aad_in,
    input  logic [4:0]       aad_byte_len,
    input  logic             aad_valid,
    output logic             aad_req,
    input  logic [127:0]     ct_in,
    input  logic [4:0]       ct_byte_len,
    input  logic             ct_valid,
    output logic             ct_req,
    output logic [127:0]     gh_data,
    output logic             gh_valid,
    input  logic             gh_ready,
    output logic             gh_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AAD,
        S_CT,
        S_LEN,
        S_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] aad_cnt;
    logic [CNT_W-1:0] ct_cnt;
    logic [CNT_W-1:0] aad_tot;
    logic [CNT_W-1:0] ct_tot;
    logic [LEN_W-1:0] aad_bits;
    logic [LEN_W-1:0] ct_bits;

    logic slot_free;
    logic aad_acc;
    logic ct_acc;

    // Out-of-range byte counts mean a full block.
    function automatic logic [4:0] eff_len(input logic [4:0] bl);
        eff_len = (bl == 5'd0 || bl > 5'd16) ? 5'd16 : bl;
    endfunction

    // Zero every byte at or beyond the valid length; byte 0 is the MSB.
    function automatic logic [127:0] mask_blk(
        input logic [127:0] d,
        input logic [4:0]   bl
    );
        logic [4:0] n;
        n = eff_len(bl);
        mask_blk = d;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) >= n) begin
                mask_blk[127-8*i -: 8] = 8'h00;
            end
        end
    endfunction

    function automatic logic [LEN_W-1:0] bits_of(input logic [4:0] bl);
        bits_of = LEN_W'({eff_len(bl), 3'b000});
    endfunction

    // Handshake qualifiers for the single output slot.
    always_comb begin
        slot_free = !gh_valid || gh_ready;
        aad_req   = (state == S_AAD) && slot_free;
        ct_req    = (state == S_CT) && slot_free;
        aad_acc   = aad_req && aad_valid;
        ct_acc    = ct_req && ct_valid;
        busy      = (state != S_IDLE);
    end

    // Message sequencer with the registered output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            aad_cnt  <= '0;
            ct_cnt   <= '0;
            aad_tot  <= '0;
            ct_tot   <= '0;
            aad_bits <= '0;
            ct_bits  <= '0;
            gh_data  <= '0;
            gh_valid <= 1'b0;
            gh_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (gh_valid && gh_ready) begin
                gh_valid <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        aad_tot  <= aad_total;
                        ct_tot   <= ct_total;
                        aad_cnt  <= '0;
                        ct_cnt   <= '0;
                        aad_bits <= '0;
                        ct_bits  <= '0;
                        if (aad_total != '0) begin
                            state <= S_AAD;
                        end else if (ct_total != '0) begin
                            state <= S_CT;
                        end else begin
                            state <= S_LEN;
                        end
                    end
                end
                S_AAD: begin
                    if (aad_acc) begin
                        gh_data  <= mask_blk(aad_in, aad_byte_len);
                        gh_valid <= 1'b1;
                        gh_last  <= 1'b0;
                        aad_bits <= aad_bits + bits_of(aad_byte_len);
                        aad_cnt  <= aad_cnt + 1'b1;
                        if (aad_cnt + 1'b1 == aad_tot) begin
                            state <= (ct_tot != '0) ? S_CT : S_LEN;
                        end
                    end
                end
                S_CT: begin
                    if (ct_acc) begin
                        gh_data  <= mask_blk(ct_in, ct_byte_len);
                        gh_valid <= 1'b1;
                        gh_last  <= 1'b0;
                        ct_bits  <= ct_bits + bits_of(ct_byte_len);
                        ct_cnt   <= ct_cnt + 1'b1;
                        if (ct_cnt + 1'b1 == ct_tot) begin
                            state <= S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (slot_free) begin
                        gh_data  <= {aad_bits, ct_bits};
                        gh_valid <= 1'b1;
                        gh_last  <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (gh_valid && gh_ready) begin
                        gh_last <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcm_ghash_sched.sv
// Scoreboard bench for gcm_ghash_sched.
// Directed GCM message vectors with hand-computed GHASH beats.
module tb_gcm_ghash_sched;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [15:0]  aad_total;
    logic [15:0]  ct_total;
    logic [127:0] aad_in;
    logic [4:0]   aad_byte_len;
    logic         aad_valid;
    logic         aad_req;
    logic [127:0] ct_in;
    logic [4:0]   ct_byte_len;
    logic         ct_valid;
    logic         ct_req;
    logic [127:0] gh_data;
    logic         gh_valid;
    logic         gh_ready;
    logic         gh_last;
    logic         busy;
    logic         done;

    gcm_ghash_sched #(.CNT_W(16), .LEN_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .aad_total    (aad_total),
        .ct_total     (ct_total),
        .aad_in       (aad_in),
        .aad_byte_len (aad_byte_len),
        .aad_valid    (aad_valid),
        .aad_req      (aad_req),
        .ct_in        (ct_in),
        .ct_byte_len  (ct_byte_len),
        .ct_valid     (ct_valid),
        .ct_req       (ct_req),
        .gh_data      (gh_data),
        .gh_valid     (gh_valid),
        .gh_ready     (gh_ready),
        .gh_last      (gh_last),
        .busy         (busy),
        .done         (done)
    );

    localparam logic [127:0] AAD0  = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    localparam logic [127:0] AAD1  = 128'habaddad2111111112222222233333333;
    localparam logic [127:0] AAD1M = 128'habaddad2000000000000000000000000;
    localparam logic [127:0] CT0   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1   = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] CT2   = 128'hfedcba9876543210fedcba9876543210;
    localparam logic [127:0] CT3   = 128'hdeadbeefcafebabe0badf00d12345678;
    localparam logic [127:0] CT3M  = 128'hdeadbeefcafebabe0badf00d00000000;
    localparam logic [127:0] LENA  = 128'h00000000000000a0_00000000000001e0;
    localparam logic [127:0] LENB  = 128'h0000000000000000_0000000000000080;

    int checks;
    int errors;
    int beats_acc;
    int done_cnt;
    bit pend_done;
    bit aad_req_seen;
    logic [128:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted GHASH beat.
    initial begin
        logic [128:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done || pend_done) begin
                    chk("done_pulse", 128'(done), 128'(pend_done));
                    if (done) done_cnt++;
                end
                pend_done = 1'b0;
                if (aad_req) aad_req_seen = 1'b1;
                if (aad_req && ct_req) begin
                    checks++;
                    errors++;
                    $display("FAIL req_excl got both req high want one");
                end
                if (gh_valid && gh_ready) begin
                    beats_acc++;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_extra got %h want none",
                                 gh_data);
                    end else begin
                        e = sb_q.pop_front();
                        chk("beat_data", gh_data, e[127:0]);
                        chk("beat_last", 128'(gh_last), 128'(e[128]));
                        if (e[128]) pend_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic start_msg(input logic [15:0] na, input logic [15:0] nc);
        @(posedge clk); #1;
        start = 1'b1;
        aad_total = na;
        ct_total = nc;
        @(posedge clk); #1;
        start = 1'b0;
        aad_total = 16'd7;
        ct_total = 16'd7;
    endtask

    task automatic send(input bit is_ct, input logic [127:0] d,
                        input logic [4:0] bl, input logic [127:0] exp);
        bit ok;
        ok = 1'b0;
        sb_q.push_back({1'b0, exp});
        if (is_ct) begin
            ct_in = d; ct_byte_len = bl; ct_valid = 1'b1;
        end else begin
            aad_in = d; aad_byte_len = bl; aad_valid = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (is_ct ? ct_req : aad_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout got no req want req");
        end
        @(posedge clk); #1;
        aad_valid = 1'b0;
        ct_valid = 1'b0;
    endtask

    task automatic wait_done();
        int b;
        bit ok;
        b = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_cnt > b) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", 128'(ok), 128'd1);
        chk("sb_empty", 128'(sb_q.size()), 128'd0);
        @(negedge clk);
        chk("idle_busy", 128'(busy), 128'd0);
    endtask

    task automatic run_nominal(input bit bp);
        int b0;
        b0 = beats_acc;
        start_msg(16'd2, 16'd4);
        fork
            begin
                send(1'b0, AAD0, 5'd16, AAD0);
                send(1'b0, AAD1, 5'd4, AAD1M);
                send(1'b1, CT0, 5'd16, CT0);
                send(1'b1, CT1, 5'd16, CT1);
                send(1'b1, CT2, 5'd16, CT2);
                send(1'b1, CT3, 5'd12, CT3M);
                sb_q.push_back({1'b1, LENA});
            end
            begin
                if (bp) begin
                    for (int i = 0; i < 60; i++) begin
                        @(posedge clk); #1;
                        if (beats_acc >= b0 + 1) break;
                    end
                    gh_ready = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        chk("bp_data", gh_data, AAD1M);
                        chk("bp_valid", 128'(gh_valid), 128'd1);
                        chk("bp_reqs", 128'({aad_req, ct_req}), 128'd0);
                    end
                    @(posedge clk); #1;
                    gh_ready = 1'b1;
                    start = 1'b1;
                    aad_total = 16'd1;
                    ct_total = 16'd0;
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
        join
        wait_done();
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {gh_data}, 128'd0);
        chk(nm, 128'({gh_valid, gh_last, aad_req, ct_req, busy, done}),
            128'd0);
    endtask

    initial begin
        checks = 0; errors = 0; beats_acc = 0; done_cnt = 0;
        pend_done = 1'b0; aad_req_seen = 1'b0;
        rst_n = 1'b1; start = 1'b0;
        aad_total = '0; ct_total = '0;
        aad_in = '0; aad_byte_len = '0; aad_valid = 1'b0;
        ct_in = '0; ct_byte_len = '0; ct_valid = 1'b0;
        gh_ready = 1'b1;

        #3 rst_n = 1'b0;
        #1 chk_all_zero("reset_async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_valid", 128'(gh_valid), 128'd0);

        run_nominal(1'b0);
        run_nominal(1'b1);

        aad_req_seen = 1'b0;
        start_msg(16'd0, 16'd1);
        send(1'b1, CT0, 5'd0, CT0);
        sb_q.push_back({1'b1, LENB});
        wait_done();
        chk("no_aad_req", 128'(aad_req_seen), 128'd0);

        sb_q.push_back({1'b1, 128'd0});
        start_msg(16'd0, 16'd0);
        wait_done();

        start_msg(16'd2, 16'd4);
        send(1'b0, AAD0, 5'd16, AAD0);
        send(1'b0, AAD1, 5'd4, AAD1M);
        send(1'b1, CT0, 5'd16, CT0);
        send(1'b1, CT1, 5'd16, CT1);
        rst_n = 1'b0;
        #1 chk_all_zero("abort_zero");
        sb_q.delete();
        pend_done = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", 128'(busy), 128'd0);
        chk("abort_quiet", 128'({gh_valid, done}), 128'd0);
        run_nominal(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
